// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies LEN 32-bit words from a source range to a
// destination range, one read then one write per word, with halt, error and timeout handling.
module wb_copy_master #(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ctrl_start,
  input  logic             ctrl_halt,
  input  logic [31:0]      cfg_src_adr,
  input  logic [31:0]      cfg_dst_adr,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             ctrl_busy,
  output logic             ctrl_done,
  output logic             ctrl_err,
  output logic [LEN_W-1:0] xfer_count,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic [15:0]      tmo;
  logic             halt_req;

  logic             start_ok;
  logic             timed_out;
  logic [LEN_W-1:0] count_next;
  logic [31:0]      src_next;
  logic [31:0]      dst_next;

  assign start_ok   = ctrl_start & ~ctrl_halt;
  assign timed_out  = (tmo == TMO_LAST);
  assign count_next = xfer_count + LEN_W'(1);
  assign src_next   = src + 32'd4;
  assign dst_next   = dst + 32'd4;

  // wbm_dat_o doubles as the captured read word between RD and WR.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      tmo        <= '0;
      halt_req   <= 1'b0;
      ctrl_busy  <= 1'b0;
      ctrl_done  <= 1'b0;
      ctrl_err   <= 1'b0;
      xfer_count <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'hF;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
    end else begin
      wbm_sel_o <= 4'hF;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          ctrl_busy <= 1'b0;
          ctrl_done <= 1'b0;
          if (start_ok) begin
            src        <= cfg_src_adr;
            dst        <= cfg_dst_adr;
            len        <= cfg_len;
            xfer_count <= '0;
            ctrl_err   <= 1'b0;
            halt_req   <= 1'b0;
            tmo        <= '0;
            if (cfg_len == '0) begin
              state     <= S_DONE;
              ctrl_done <= 1'b1;
            end else begin
              state     <= S_RD;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_adr_o <= {cfg_src_adr[31:2], 2'b00};
              ctrl_busy <= 1'b1;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end

        S_RD: begin
          if (ctrl_halt) halt_req <= 1'b1;
          if (wbm_err_i || (!wbm_ack_i && timed_out)) begin
            state     <= S_ERR;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            ctrl_busy <= 1'b0;
            ctrl_err  <= 1'b1;
          end else if (wbm_ack_i) begin
            state     <= S_WR;
            wbm_dat_o <= wbm_dat_i;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= {dst[31:2], 2'b00};
            tmo       <= '0;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        S_WR: begin
          if (ctrl_halt) halt_req <= 1'b1;
          if (wbm_err_i || (!wbm_ack_i && timed_out)) begin
            state     <= S_ERR;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            ctrl_busy <= 1'b0;
            ctrl_err  <= 1'b1;
          end else if (wbm_ack_i) begin
            xfer_count <= count_next;
            src        <= src_next;
            dst        <= dst_next;
            tmo        <= '0;
            wbm_we_o   <= 1'b0;
            if (count_next == len) begin
              state     <= S_DONE;
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              ctrl_busy <= 1'b0;
              ctrl_done <= 1'b1;
            end else if (halt_req || ctrl_halt) begin
              state     <= S_IDLE;
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              ctrl_busy <= 1'b0;
            end else begin
              state     <= S_RD;
              wbm_adr_o <= {src_next[31:2], 2'b00};
            end
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Randomized scoreboard bench for wb_copy_master: a behavioural slave supplies address-derived
// read data and injected faults; expected bus accesses are queued and matched by a monitor.
module tb_wb_copy_master;

  localparam int LEN_W = 16;
  localparam int TMO   = 16;
  localparam int F_NONE = 0, F_ERR = 1, F_NOACK = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ctrl_start = 1'b0, ctrl_halt = 1'b0;
  logic [31:0]      cfg_src_adr = '0, cfg_dst_adr = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             ctrl_busy, ctrl_done, ctrl_err;
  logic [LEN_W-1:0] xfer_count;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic             wbm_ack_i, wbm_err_i;

  always #5 clk = ~clk;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .ctrl_start(ctrl_start), .ctrl_halt(ctrl_halt),
    .cfg_src_adr(cfg_src_adr), .cfg_dst_adr(cfg_dst_adr), .cfg_len(cfg_len),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .xfer_count(xfer_count),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave memory content is a fixed function of the word address.
  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a * 32'd2654435761);
  endfunction

  // Behavioural slave: mode 0 acks in the same cycle, mode 1 one cycle later.
  int unsigned mode = 0, fault_idx = 0, acc_n = 0, acc_base = 0, wait_cnt = 0;
  int          fault_kind = F_NONE;
  logic        bus_req, ready, flt;

  assign bus_req   = wbm_cyc_o & wbm_stb_o;
  assign ready     = (mode == 0) || (wait_cnt != 0);
  assign flt       = (fault_kind != F_NONE) && ((acc_n - acc_base) == fault_idx);
  assign wbm_ack_i = bus_req && ready && !(flt && fault_kind == F_NOACK);
  assign wbm_err_i = bus_req && ready && flt && fault_kind == F_ERR;
  assign wbm_dat_i = rd_data(wbm_adr_o);

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (bus_req && (wbm_ack_i || wbm_err_i)) begin
      acc_n    <= acc_n + 1;
      wait_cnt <= 0;
    end else if (bus_req) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_act, mon_exp;
  int   done_cnt = 0, cyc_cycles = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wbm_cyc_o) cyc_cycles++;
      if (ctrl_done) begin
        done_cnt++;
        chk("done_while_idle", {wbm_cyc_o, ctrl_busy}, 2'b00);
      end
      if (bus_req && wbm_ack_i && !wbm_err_i) begin
        mon_act.we  = wbm_we_o;
        mon_act.adr = wbm_adr_o;
        mon_act.dat = wbm_we_o ? wbm_dat_o : 32'h0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_access actual=%0h expected=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("bus_access", {mon_act, wbm_sel_o}, {mon_exp, 4'hF});
        end
      end
    end
  end

  // Reference: the first n accesses of the ideal alternating read/write sequence.
  task automatic push_seq(input logic [31:0] src, input logic [31:0] dst, input int unsigned n);
    txn_t t;
    for (int unsigned k = 0; k < n; k++) begin
      t.we  = k[0];
      t.adr = ((t.we ? dst : src) + 32'd4 * (k / 2)) & 32'hFFFF_FFFC;
      t.dat = t.we ? rd_data((src + 32'd4 * (k / 2)) & 32'hFFFF_FFFC) : 32'h0;
      exp_q.push_back(t);
    end
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int unsigned len,
                          input int unsigned mode_i, input int fk, input int unsigned fidx,
                          input int halt_w);
    int unsigned n_acc, exp_cnt, t;
    logic        exp_err;
    int          exp_done, guard;
    if (halt_w >= 0) begin
      n_acc = 2 * (halt_w + 1); exp_cnt = halt_w + 1; exp_err = 1'b0; exp_done = 0;
    end else if (fk != F_NONE) begin
      n_acc = fidx; exp_cnt = fidx / 2; exp_err = 1'b1; exp_done = 0;
    end else begin
      n_acc = 2 * len; exp_cnt = len; exp_err = 1'b0; exp_done = 1;
    end
    push_seq(src, dst, n_acc);

    @(negedge clk);
    mode = mode_i; fault_kind = fk; fault_idx = fidx; acc_base = acc_n;
    cfg_src_adr = src; cfg_dst_adr = dst; cfg_len = LEN_W'(len);
    ctrl_start = 1'b1; done_cnt = 0; cyc_cycles = 0;
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    @(negedge clk);
    if (len == 0)
      chk("zero_len_done", {ctrl_done, wbm_cyc_o, ctrl_err}, 3'b100);
    else
      chk("start_launch", {wbm_cyc_o, wbm_stb_o, wbm_we_o, ctrl_busy, ctrl_err, xfer_count, wbm_adr_o},
          {5'b11010, 16'h0, src & 32'hFFFF_FFFC});

    if (halt_w >= 0) begin
      guard = 0;
      while (!(bus_req && !wbm_we_o && (acc_n - acc_base) == 2 * halt_w) && guard < 500) begin
        @(negedge clk); guard++;
      end
      chk("halt_point_reached", guard < 500, 1'b1);
      ctrl_halt = 1'b1;
    end

    if (fk == F_NOACK) begin
      guard = 0;
      while (!(bus_req && (acc_n - acc_base) == fidx) && guard < 500) begin
        @(negedge clk); guard++;
      end
      t = 0;
      while (!ctrl_err && t < 100) begin
        @(negedge clk); t++;
      end
      chk("timeout_latency", t, TMO);
      chk("timeout_cyc_low", wbm_cyc_o, 1'b0);
    end

    guard = 0;
    while (ctrl_busy && guard < 2000) begin
      @(negedge clk); guard++;
    end
    chk("busy_drops", guard < 2000, 1'b1);
    ctrl_halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("xfer_count", xfer_count, exp_cnt);
    chk("err_flag", ctrl_err, exp_err);
    chk("done_pulses", done_cnt, exp_done);
    chk("queue_drained", exp_q.size(), 0);
    chk("bus_released", {wbm_cyc_o, wbm_stb_o, ctrl_busy}, 3'b000);
    if (exp_done == 1) chk("cyc_cycles", cyc_cycles, (mode_i == 1 ? 4 : 2) * len);
    exp_q.delete();
  endtask

  initial begin
    int unsigned len, m, r, fi;
    int          hw, fk, guard;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {wbm_cyc_o, wbm_stb_o, wbm_we_o, ctrl_busy, ctrl_done, ctrl_err, wbm_sel_o,
                        wbm_adr_o, wbm_dat_o, xfer_count}, {6'b0, 4'hF, 32'h0, 32'h0, 16'h0});
    rst = 1'b0;

    run_xfer(32'h3000_0000, 32'h3000_0100, 4, 0, F_NONE, 0, -1);
    run_xfer(32'h3000_0000, 32'h0000_0100, 3, 1, F_NONE, 0, -1);
    run_xfer(32'h3000_0000, 32'h3000_0100, 8, 0, F_NONE, 0, 1);
    run_xfer(32'h3000_0000, 32'h3000_0100, 4, 0, F_ERR, 5, -1);
    run_xfer(32'h3000_0040, 32'h3000_0200, 2, 0, F_NONE, 0, -1);
    run_xfer(32'h3000_0000, 32'h3000_0100, 3, 0, F_NOACK, 0, -1);
    run_xfer(32'h3000_0000, 32'h3000_0100, 0, 0, F_NONE, 0, -1);
    run_xfer(32'hFFFF_FFFC, 32'h0000_0103, 2, 1, F_NONE, 0, -1);

    // Start is blocked when halt is asserted in the same cycle.
    @(negedge clk);
    cfg_len = 16'd3; ctrl_start = 1'b1; ctrl_halt = 1'b1;
    @(posedge clk);
    #1 ctrl_start = 1'b0; ctrl_halt = 1'b0;
    @(negedge clk);
    chk("start_blocked_by_halt", {wbm_cyc_o, ctrl_busy, ctrl_done}, 3'b000);

    // Reset in the middle of a write phase.
    push_seq(32'h3000_0000, 32'h3000_0100, 12);
    @(negedge clk);
    mode = 0; fault_kind = F_NONE; acc_base = acc_n; done_cnt = 0;
    cfg_src_adr = 32'h3000_0000; cfg_dst_adr = 32'h3000_0100; cfg_len = 16'd6; ctrl_start = 1'b1;
    @(posedge clk);
    #1 ctrl_start = 1'b0;
    guard = 0;
    while (!(wbm_we_o && (acc_n - acc_base) >= 3) && guard < 200) begin
      @(negedge clk); guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_write", {wbm_cyc_o, wbm_stb_o, wbm_we_o, ctrl_busy, ctrl_done, ctrl_err, wbm_sel_o,
                            wbm_adr_o, wbm_dat_o, xfer_count}, {6'b0, 4'hF, 32'h0, 32'h0, 16'h0});
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("reset_no_done", done_cnt, 0);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 6);
      m   = $urandom_range(0, 1);
      r   = $urandom_range(0, 9);
      hw = -1; fk = F_NONE; fi = 0;
      if (len >= 2 && (r == 5 || r == 6)) hw = $urandom_range(0, len - 2);
      else if (len >= 1 && (r == 7 || r == 8)) begin fk = F_ERR; fi = $urandom_range(0, 2 * len - 1); end
      else if (len >= 1 && r == 9) begin fk = F_NOACK; fi = $urandom_range(0, 2 * len - 1); end
      run_xfer($urandom, $urandom, len, m, fk, fi, hw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
